// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller that borrows the shared ALU to form op_a*op_b mod 2^WIDTH.
// Each iteration spends three cycles on the ALU: conditional ADD, LSL of the multiplicand, LSR of the multiplier.
module alu_mul_sequencer #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_LSL  = 4'b0100;
    localparam logic [3:0] OP_LSR  = 4'b0011;
    localparam logic [3:0] OP_NONE = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHA,
        S_SHB,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_iter;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // The LSR result is the shifted multiplier, so a zero here means no set bits remain.
    assign last_iter = (cnt_q == CNT_LAST) || (EARLY_EXIT && (alu_out == '0));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = OP_NONE;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                alu_a    = acc_q;
                alu_b    = a_q;
                alu_ctrl = OP_ADD;
                if (b_q[0]) begin
                    acc_d = alu_out;
                end
                state_d = S_SHA;
            end
            S_SHA: begin
                alu_a    = a_q;
                alu_b    = ONE;
                alu_ctrl = OP_LSL;
                a_d      = alu_out;
                state_d  = S_SHB;
            end
            S_SHB: begin
                alu_a    = b_q;
                alu_b    = ONE;
                alu_ctrl = OP_LSR;
                b_d      = alu_out;
                if (last_iter) begin
                    result_d = acc_q;
                    state_d  = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: one early-exit and one full-length instance, each with its own ALU model,
// checked by a scoreboard of expected products and done-edge numbers.
module tb_alu_mul_sequencer;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         start_e, start_n;
    logic [W-1:0] a_e, b_e, a_n, b_n;
    logic         busy_e, done_e, busy_n, done_n;
    logic [W-1:0] res_e, alua_e, alub_e, aluo_e;
    logic [W-1:0] res_n, alua_n, alub_n, aluo_n;
    logic [3:0]   ctrl_e, ctrl_n;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b0100: return a << b;
            4'b0011: return a >> b;
            default: return '0;
        endcase
    endfunction

    assign aluo_e = alu_f(alua_e, alub_e, ctrl_e);
    assign aluo_n = alu_f(alua_n, alub_n, ctrl_n);

    alu_mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .reset_n(reset_n), .start(start_e), .op_a(a_e), .op_b(b_e),
        .busy(busy_e), .done(done_e), .result(res_e),
        .alu_a(alua_e), .alu_b(alub_e), .alu_ctrl(ctrl_e), .alu_out(aluo_e));

    alu_mul_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_nx (
        .clk(clk), .reset_n(reset_n), .start(start_n), .op_a(a_n), .op_b(b_n),
        .busy(busy_n), .done(done_n), .result(res_n),
        .alu_a(alua_n), .alu_b(alub_n), .alu_ctrl(ctrl_n), .alu_out(aluo_n));

    typedef struct {
        logic [W-1:0] res;
        int           done_edge;
    } job_t;

    job_t q_e[$];
    job_t q_n[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int iters(input logic [W-1:0] b, input bit ee);
        if (!ee) return W;
        for (int i = W - 1; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
    endfunction

    function automatic job_t make_job(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input bit ee, input int acc_edge);
        job_t j;
        j.res       = a * b;
        j.done_edge = acc_edge + 3 * iters(b, ee);
        return j;
    endfunction

    always @(negedge clk) begin
        job_t j;
        if (done_e) begin
            if (q_e.size() == 0) check("spurious_done_e", 32'd1, 32'd0);
            else begin
                j = q_e.pop_front();
                check("result_e", res_e, j.res);
                check("done_edge_e", cyc, j.done_edge);
            end
        end
        if (done_n) begin
            if (q_n.size() == 0) check("spurious_done_n", 32'd1, 32'd0);
            else begin
                j = q_n.pop_front();
                check("result_n", res_n, j.res);
                check("done_edge_n", cyc, j.done_edge);
            end
        end
    end

    // Drives a one-cycle start to an idle instance; returns the accepting edge number.
    task automatic launch(input bit nx, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int acc_edge);
        @(negedge clk);
        acc_edge = cyc + 1;
        if (nx) begin
            start_n = 1'b1; a_n = a; b_n = b;
            q_n.push_back(make_job(a, b, 1'b0, acc_edge));
        end else begin
            start_e = 1'b1; a_e = a; b_e = b;
            q_e.push_back(make_job(a, b, 1'b1, acc_edge));
        end
        @(negedge clk);
        start_e = 1'b0;
        start_n = 1'b0;
    endtask

    task automatic drain(input bit nx, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if ((nx ? q_n.size() : q_e.size()) == 0) break;
            @(negedge clk);
        end
        check(tag, nx ? q_n.size() : q_e.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [3:0] pat [3];
    int         acc;

    initial begin
        pat[0] = 4'b0000; pat[1] = 4'b0100; pat[2] = 4'b0011;
        reset_n = 1'b0;
        start_e = 1'b0; start_n = 1'b0;
        a_e = '0; b_e = '0; a_n = '0; b_n = '0;

        // Reset state and idle stability
        #3;
        check("rst_busy_e", busy_e, 0);
        check("rst_done_e", done_e, 0);
        check("rst_result_e", res_e, 0);
        check("rst_ctrl_e", ctrl_e, 4'hF);
        check("rst_busy_n", busy_n, 0);
        check("rst_result_n", res_n, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy_e", busy_e, 0);
        check("idle_result_e", res_e, 0);
        check("idle_ctrl_e", ctrl_e, 4'hF);
        check("idle_alu_a_e", alua_e, 0);
        check("idle_busy_n", busy_n, 0);

        // 3*5 early exit, with ALU opcode sequence
        launch(1'b0, 16'd3, 16'd5, acc);
        check("add0_alu_a", alua_e, 0);
        check("add0_alu_b", alub_e, 3);
        for (int i = 0; i < 9; i++) begin
            check("ctrl_seq", ctrl_e, pat[i % 3]);
            @(negedge clk);
        end
        drain(1'b0, 20, "drain_3x5_e");
        check("result_held", res_e, 16'h000F);
        check("ctrl_after_done", ctrl_e, 4'hF);

        // Zero multiplier and full-width multiplier
        launch(1'b0, 16'h1234, 16'h0000, acc);
        drain(1'b0, 20, "drain_b0_e");
        launch(1'b0, 16'hFFFF, 16'hFFFF, acc);
        drain(1'b0, 80, "drain_ffff_e");
        check("ffff_result", res_e, 16'h0001);

        // Full-length run; start pulse mid-job must be ignored
        launch(1'b1, 16'd3, 16'd5, acc);
        repeat (18) @(negedge clk);
        start_n = 1'b1; a_n = 16'd7; b_n = 16'd7;
        @(negedge clk);
        start_n = 1'b0;
        check("busy_during_ignored", busy_n, 1);
        drain(1'b1, 60, "drain_3x5_n");
        check("nx_result_held", res_n, 16'h000F);
        a_n = 16'd2; b_n = 16'd2;
        launch(1'b1, 16'h0101, 16'h8000, acc);
        drain(1'b1, 60, "drain_msb_n");

        // Reset aborts a job mid-operation
        launch(1'b0, 16'd9, 16'd9, acc);
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", busy_e, 0);
        check("abort_result", res_e, 0);
        check("abort_ctrl", ctrl_e, 4'hF);
        q_e.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_result_after", res_e, 0);
        launch(1'b0, 16'd9, 16'd9, acc);
        drain(1'b0, 20, "drain_9x9_e");
        check("restart_result", res_e, 16'h0051);

        // Back-to-back with start held high
        @(negedge clk);
        acc = cyc + 1;
        start_e = 1'b1; a_e = 16'd3; b_e = 16'd5;
        q_e.push_back(make_job(16'd3, 16'd5, 1'b1, acc));
        q_e.push_back(make_job(16'd2, 16'd6, 1'b1, acc + 11));
        @(negedge clk);
        a_e = 16'd2; b_e = 16'd6;
        repeat (10) @(negedge clk);
        check("b2b_idle_gap", busy_e, 0);
        @(negedge clk);
        start_e = 1'b0;
        check("b2b_second_busy", busy_e, 1);
        drain(1'b0, 30, "drain_b2b_e");
        check("b2b_result", res_e, 16'h000C);
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
